// File: rtl/bin_to_bcd8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin_to_bcd8 : sequential double-dabble binary to 8-digit BCD converter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module bin_to_bcd8 #(
  parameter int BIN_W = 27
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       d1,
  output logic [3:0]       d2,
  output logic [3:0]       d3,
  output logic [3:0]       d4,
  output logic [3:0]       d5,
  output logic [3:0]       d6,
  output logic [3:0]       d7,
  output logic [3:0]       d8
);

  localparam int                 c_cnt_w = $clog2(BIN_W);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BIN_W - 1);
  localparam logic [BIN_W-1:0]   c_max   = BIN_W'(99_999_999);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_sr;
  logic [31:0]        r_bcd;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ovf_pend;
  logic [31:0]        w_adj;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_nib
      assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                         : r_bcd[4*i +: 4];
    end
  endgenerate

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sr       <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      {d8, d7, d6, d5, d4, d3, d2, d1} <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr       <= bin;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (bin > c_max);
            busy       <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= {w_adj[30:0], r_sr[BIN_W-1]};
          r_sr  <= r_sr << 1;
          r_cnt <= r_cnt + 1'b1;
          // A bit carried out of the top digit can only mean the value overflowed.
          r_ovf_pend <= r_ovf_pend | w_adj[31];
          if (r_cnt == c_last) r_state <= FINISH;
        end
        FINISH: begin
          ovf <= r_ovf_pend;
          if (r_ovf_pend) {d8, d7, d6, d5, d4, d3, d2, d1} <= 32'hFFFF_FFFF;
          else            {d8, d7, d6, d5, d4, d3, d2, d1} <= r_bcd;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bin_to_bcd8 : directed self-checking bench for bin_to_bcd8
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_bin_to_bcd8;

  localparam int BIN_W = 27;

  logic             mclk;
  logic             rst_n;
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy, done, ovf;
  logic [3:0]       d1, d2, d3, d4, d5, d6, d7, d8;
  logic [31:0]      digits;

  int n_pass  = 0;
  int n_total = 0;

  assign digits = {d8, d7, d6, d5, d4, d3, d2, d1};

  bin_to_bcd8 #(.BIN_W(BIN_W)) dut (
    .mclk (mclk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy (busy), .done (done),  .ovf  (ovf),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse start for one edge, then watch 40 edges counting busy/done behaviour.
  task automatic run_conv(input logic [BIN_W-1:0] v, output int lat, output int busy_cyc,
                          output int done_cnt, output bit both);
    lat = -1; busy_cyc = 0; done_cnt = 0; both = 1'b0;
    @(negedge mclk); bin = v; start = 1'b1;
    @(posedge mclk); #1; start = 1'b0;
    if (busy) busy_cyc++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge mclk); #1;
      if (busy) busy_cyc++;
      if (busy && done) both = 1'b1;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
    n_total++; if (digits !== 32'h0) $display("FAIL reset_digits: got %h want 00000000", digits); else n_pass++;
    @(negedge mclk); rst_n = 1'b1;
  endtask

  task automatic test_zero;
    int lat, bc, dc; bit both;
    run_conv('0, lat, bc, dc, both);
    n_total++; if (lat !== 28) $display("FAIL zero_latency: got %0d want 28", lat); else n_pass++;
    n_total++; if (bc !== 28) $display("FAIL zero_busy_cycles: got %0d want 28", bc); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL zero_done_count: got %0d want 1", dc); else n_pass++;
    n_total++; if (both !== 1'b0) $display("FAIL zero_busy_and_done: got %b want 0", both); else n_pass++;
    n_total++; if (digits !== 32'h0) $display("FAIL zero_digits: got %h want 00000000", digits); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL zero_ovf: got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_pattern;
    int lat, bc, dc; bit both;
    run_conv(27'd12_345_678, lat, bc, dc, both);
    n_total++; if (digits !== 32'h1234_5678) $display("FAIL pattern_digits: got %h want 12345678", digits); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL pattern_ovf: got %b want 0", ovf); else n_pass++;
    n_total++; if (lat !== 28) $display("FAIL pattern_latency: got %0d want 28", lat); else n_pass++;
  endtask

  task automatic test_overflow;
    int lat, bc, dc; bit both;
    run_conv(27'd99_999_999, lat, bc, dc, both);
    n_total++; if (digits !== 32'h9999_9999) $display("FAIL max_digits: got %h want 99999999", digits); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL max_ovf: got %b want 0", ovf); else n_pass++;
    run_conv(27'd100_000_000, lat, bc, dc, both);
    n_total++; if (digits !== 32'hFFFF_FFFF) $display("FAIL ovf_digits: got %h want ffffffff", digits); else n_pass++;
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", ovf); else n_pass++;
    run_conv(27'd134_217_727, lat, bc, dc, both);
    n_total++; if (digits !== 32'hFFFF_FFFF) $display("FAIL allones_digits: got %h want ffffffff", digits); else n_pass++;
    n_total++; if (ovf !== 1'b1) $display("FAIL allones_ovf: got %b want 1", ovf); else n_pass++;
    run_conv(27'd9_070_605, lat, bc, dc, both);
    n_total++; if (digits !== 32'h0907_0605) $display("FAIL ovf_clear_digits: got %h want 09070605", digits); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL ovf_clear_flag: got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_ignore_start;
    int lat = -1, dc = 0;
    @(negedge mclk); bin = 27'd5; start = 1'b1;
    @(posedge mclk); #1; start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge mclk); #1;
      if (k == 10) begin bin = 27'd77; start = 1'b1; end
      if (k == 11) start = 1'b0;
      if (k == 15) bin = 27'd12_345;
      if (done) begin dc++; if (lat < 0) lat = k; end
    end
    n_total++; if (digits !== 32'h0000_0005) $display("FAIL ignore_digits: got %h want 00000005", digits); else n_pass++;
    n_total++; if (dc !== 1) $display("FAIL ignore_done_count: got %0d want 1", dc); else n_pass++;
    n_total++; if (lat !== 28) $display("FAIL ignore_latency: got %0d want 28", lat); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int lat = -1, dc = 0;
    @(negedge mclk); bin = 27'd42; start = 1'b1;
    @(posedge mclk); #1; start = 1'b0;
    for (int k = 1; k <= 12; k++) begin @(posedge mclk); #1; end
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (digits !== 32'h0) $display("FAIL abort_digits: got %h want 00000000", digits); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(posedge mclk); #1;
      if (done || busy) dc++;
    end
    n_total++; if (dc !== 0) $display("FAIL abort_held: got %0d active samples want 0", dc); else n_pass++;
    // start is already high when reset releases, so the very next edge is T0.
    @(negedge mclk); bin = 27'd42; start = 1'b1; rst_n = 1'b1;
    @(posedge mclk); #1; start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL first_edge_start: got busy %b want 1", busy); else n_pass++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge mclk); #1;
      if (done) begin dc++; if (lat < 0) lat = k; end
    end
    n_total++; if (digits !== 32'h0000_0042) $display("FAIL abort_rerun_digits: got %h want 00000042", digits); else n_pass++;
    n_total++; if (dc !== 1 || lat !== 28) $display("FAIL abort_rerun_done: got count %0d latency %0d want 1 and 28", dc, lat); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int first = -1, second = -1, ndone = 0;
    bit partial = 1'b0;
    logic [31:0] prev, got1, got2;
    got1 = '0; got2 = '0;
    prev = digits;
    @(negedge mclk); bin = 27'd10; start = 1'b1;
    @(posedge mclk); #1;
    bin = 27'd20;
    for (int k = 1; k <= 70; k++) begin
      @(posedge mclk); #1;
      if (digits !== prev && !done) partial = 1'b1;
      prev = digits;
      if (done) begin
        ndone++;
        if (first < 0) begin first = k; got1 = digits; end
        else if (second < 0) begin second = k; got2 = digits; start = 1'b0; end
      end
    end
    n_total++; if (got1 !== 32'h0000_0010) $display("FAIL b2b_first_digits: got %h want 00000010", got1); else n_pass++;
    n_total++; if (got2 !== 32'h0000_0020) $display("FAIL b2b_second_digits: got %h want 00000020", got2); else n_pass++;
    n_total++; if (second - first !== 29) $display("FAIL b2b_spacing: got %0d want 29", second - first); else n_pass++;
    n_total++; if (first !== 28) $display("FAIL b2b_first_latency: got %0d want 28", first); else n_pass++;
    n_total++; if (partial !== 1'b0) $display("FAIL b2b_partial: got %b want 0", partial); else n_pass++;
    n_total++; if (ndone !== 2) $display("FAIL b2b_done_count: got %0d want 2", ndone); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bin = '0;
    test_reset;
    test_zero;
    test_pattern;
    test_overflow;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin_to_bcd8.md
BIN_TO_BCD8 -- requirements
Module: bin_to_bcd8

Interface
REQ-001 SHALL have parameter BIN_W, default 27, width of binary input; supported range 27..32.
REQ-002 SHALL have port mclk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  conversion request, sampled on mclk rising edge.
REQ-005 SHALL have port bin  input  BIN_W  unsigned binary value to convert, sampled with start.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port done  output  1  single-cycle pulse when new digits are valid.
REQ-008 SHALL have port ovf  output  1  high when last accepted value exceeded 99,999,999.
REQ-009 SHALL have ports d1..d8  output  4 each  BCD digits; d1 = ones, d8 = ten-millions; drive the 8 hex-digit inputs of the display driver directly.

Function
REQ-010 SHALL implement sequential double-dabble, one input bit per clock, MSB first.
REQ-011 SHALL use FSM states IDLE, SHIFT, FINISH; reset state IDLE.
REQ-012 IDLE: on edge with start=1, SHALL capture bin, clear 32-bit BCD scratch, clear bit counter, latch overflow compare, go to SHIFT.
REQ-013 IDLE with start=0 SHALL hold all outputs.
REQ-014 SHIFT: each edge SHALL add 3 to every scratch nibble >= 5, then shift {scratch, shift-reg} left one bit, increment counter.
REQ-015 SHIFT SHALL go to FINISH on the edge that processes bit index 0 (the BIN_W-th SHIFT edge).
REQ-016 FINISH: on next edge SHALL load d1..d8 from scratch, update ovf, assert done, return to IDLE.
REQ-017 Latency: start edge T0, SHIFT edges T1..T(BIN_W), outputs/done change at edge T(BIN_W+1) (28 edges for BIN_W=27).
REQ-018 busy SHALL be 1 from edge T0 through edge T(BIN_W+1), 0 otherwise; done SHALL be 1 for exactly the cycle after T(BIN_W+1).
REQ-019 busy and done SHALL never be 1 in the same cycle.
REQ-020 start while busy=1 SHALL be ignored; no queueing; bin changes while busy SHALL not affect result.
REQ-021 start held high continuously SHALL give back-to-back conversions every BIN_W+2 edges.
REQ-022 Overflow: if captured bin > 99,999,999, SHALL set ovf=1 and load all d1..d8 = 4'hF at FINISH; otherwise ovf=0 and true BCD digits.
REQ-023 Overflow compare SHALL use full BIN_W bits (values >= 2^27 for BIN_W up to 32 flagged).
REQ-024 d1..d8 and ovf SHALL change only at FINISH edge; between conversions SHALL hold last result (display never shows partial values).
REQ-025 All outputs SHALL be registered; no combinational path from start/bin to any output.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, ovf=0, d1..d8=0, scratch/counter=0, regardless of clock.
REQ-027 Reset mid-conversion SHALL abort it; no done pulse for aborted conversion; first start after rst_n rises is accepted normally.
REQ-028 start sampled on the first edge after rst_n deasserts SHALL be honoured.

Verification
REQ-029 bin=0, start 1 cycle -> busy 28 cycles, done pulse, d8..d1 all 0, ovf=0.
REQ-030 bin=12,345,678 -> d8..d1 = 1,2,3,4,5,6,7,8, ovf=0, done exactly 28 edges after start edge.
REQ-031 bin=99,999,999 -> all digits 9, ovf=0; then bin=100,000,000 -> all digits 4'hF, ovf=1.
REQ-032 start=1 with bin=5 then pulse start with bin=77 at T0+10 -> second start ignored, result d1=5, others 0, single done.
REQ-033 start with bin=42, rst_n low at T0+12 for 3 cycles -> outputs 0 immediately, no done; new start bin=42 -> d2=4, d1=2.
REQ-034 start held high, bin=10 then 20 -> done pulses 29 edges apart; digits 10 then 20; no partial values visible on d1..d8.
